// File: rtl/reservation_station_if.sv
// Dispatch, result-broadcast and issue signals of the ALU reservation station.
// The slave modport is the station itself; the master side drives dispatch and broadcasts.
interface reservation_station_if #(
    parameter int ROB_LOG = 4,
    parameter int OP_LOG  = 6
);
    logic               D_enable;
    logic [OP_LOG-1:0]  D_op;
    logic [31:0]        D_Vj;
    logic [31:0]        D_Vk;
    logic               D_Jrdy;
    logic               D_Krdy;
    logic [ROB_LOG-1:0] D_Qj;
    logic [ROB_LOG-1:0] D_Qk;
    logic [31:0]        D_Imm;
    logic [ROB_LOG-1:0] D_DestRob;
    logic [31:0]        D_CurPC;
    logic               full;

    logic               B_enable;
    logic [31:0]        B_value;
    logic [ROB_LOG-1:0] B_RobId;
    logic               L_enable;
    logic [31:0]        L_value;
    logic [ROB_LOG-1:0] L_RobId;

    logic               RS_valid;
    logic [OP_LOG-1:0]  RS_op;
    logic [31:0]        RS_Vj;
    logic [31:0]        RS_Vk;
    logic [31:0]        RS_Imm;
    logic [ROB_LOG-1:0] RS_DestRob;
    logic [31:0]        RS_CurPC;

    modport master (
        output D_enable, D_op, D_Vj, D_Vk, D_Jrdy, D_Krdy, D_Qj, D_Qk, D_Imm, D_DestRob, D_CurPC,
        output B_enable, B_value, B_RobId, L_enable, L_value, L_RobId,
        input  full, RS_valid, RS_op, RS_Vj, RS_Vk, RS_Imm, RS_DestRob, RS_CurPC
    );

    modport slave (
        input  D_enable, D_op, D_Vj, D_Vk, D_Jrdy, D_Krdy, D_Qj, D_Qk, D_Imm, D_DestRob, D_CurPC,
        input  B_enable, B_value, B_RobId, L_enable, L_value, L_RobId,
        output full, RS_valid, RS_op, RS_Vj, RS_Vk, RS_Imm, RS_DestRob, RS_CurPC
    );
endinterface

// File: rtl/reservation_station.sv
// ALU-side issue queue: holds dispatched ops until both operands are known, wakes them from the
// ALU/LSB broadcasts and issues the lowest-index ready entry, one per cycle, into the FU.
module reservation_station #(
    parameter int                RS_SIZE = 16,
    parameter int                RS_LOG  = 4,
    parameter int                ROB_LOG = 4,
    parameter int                OP_LOG  = 6,
    parameter logic [OP_LOG-1:0] OP_NOP  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear,
    reservation_station_if.slave  bus
);
    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [OP_LOG-1:0]  op_vec   [RS_SIZE];
    logic [31:0]        vj_vec   [RS_SIZE];
    logic [31:0]        vk_vec   [RS_SIZE];
    logic [31:0]        imm_vec  [RS_SIZE];
    logic [ROB_LOG-1:0] dest_vec [RS_SIZE];
    logic [31:0]        pc_vec   [RS_SIZE];

    logic [RS_LOG-1:0]  free_idx;
    logic [RS_LOG-1:0]  issue_idx;
    logic               issue_found;
    logic               full;
    logic               dispatch_go;
    logic               issue_go;

    // Priority encoders: scanning downward leaves the lowest matching index.
    always_comb begin
        free_idx    = '0;
        issue_idx   = '0;
        issue_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_idx = RS_LOG'(i);
            end
            if (ready_vec[i]) begin
                issue_idx   = RS_LOG'(i);
                issue_found = 1'b1;
            end
        end
    end

    assign full        = &busy_vec;
    assign bus.full    = full;
    assign dispatch_go = rdy && !clear && bus.D_enable && !full && (bus.D_op != OP_NOP);
    assign issue_go    = rdy && !clear && issue_found;

    // Dispatch-time bypass; the LSB result wins on a (nominally impossible) double match.
    logic        dj_l_hit, dj_b_hit, dk_l_hit, dk_b_hit;
    logic        d_jrdy, d_krdy;
    logic [31:0] d_vj, d_vk;

    always_comb begin
        dj_l_hit = !bus.D_Jrdy && bus.L_enable && (bus.L_RobId == bus.D_Qj);
        dj_b_hit = !bus.D_Jrdy && bus.B_enable && (bus.B_RobId == bus.D_Qj);
        dk_l_hit = !bus.D_Krdy && bus.L_enable && (bus.L_RobId == bus.D_Qk);
        dk_b_hit = !bus.D_Krdy && bus.B_enable && (bus.B_RobId == bus.D_Qk);
        d_jrdy   = bus.D_Jrdy || dj_l_hit || dj_b_hit;
        d_krdy   = bus.D_Krdy || dk_l_hit || dk_b_hit;
        d_vj     = dj_l_hit ? bus.L_value : (dj_b_hit ? bus.B_value : bus.D_Vj);
        d_vk     = dk_l_hit ? bus.L_value : (dk_b_hit ? bus.B_value : bus.D_Vk);
    end

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            logic               busy_reg, jrdy_reg, krdy_reg;
            logic [OP_LOG-1:0]  op_reg;
            logic [31:0]        vj_reg, vk_reg, imm_reg, pc_reg;
            logic [ROB_LOG-1:0] qj_reg, qk_reg, dest_reg;
            logic               j_l_hit, j_b_hit, k_l_hit, k_b_hit;
            logic               j_wake, k_wake;

            always_comb begin
                j_l_hit = bus.L_enable && (bus.L_RobId == qj_reg);
                j_b_hit = bus.B_enable && (bus.B_RobId == qj_reg);
                k_l_hit = bus.L_enable && (bus.L_RobId == qk_reg);
                k_b_hit = bus.B_enable && (bus.B_RobId == qk_reg);
                j_wake  = busy_reg && !jrdy_reg && (j_l_hit || j_b_hit);
                k_wake  = busy_reg && !krdy_reg && (k_l_hit || k_b_hit);
            end

            always_ff @(posedge clk) begin
                if (rst || (rdy && clear)) begin
                    busy_reg <= 1'b0;
                    jrdy_reg <= 1'b0;
                    krdy_reg <= 1'b0;
                end else if (rdy) begin
                    if (dispatch_go && (free_idx == RS_LOG'(gi))) begin
                        busy_reg <= 1'b1;
                        op_reg   <= bus.D_op;
                        vj_reg   <= d_vj;
                        vk_reg   <= d_vk;
                        jrdy_reg <= d_jrdy;
                        krdy_reg <= d_krdy;
                        qj_reg   <= bus.D_Qj;
                        qk_reg   <= bus.D_Qk;
                        imm_reg  <= bus.D_Imm;
                        dest_reg <= bus.D_DestRob;
                        pc_reg   <= bus.D_CurPC;
                    end else begin
                        if (issue_go && (issue_idx == RS_LOG'(gi))) begin
                            busy_reg <= 1'b0;
                        end
                        if (j_wake) begin
                            vj_reg   <= j_l_hit ? bus.L_value : bus.B_value;
                            jrdy_reg <= 1'b1;
                        end
                        if (k_wake) begin
                            vk_reg   <= k_l_hit ? bus.L_value : bus.B_value;
                            krdy_reg <= 1'b1;
                        end
                    end
                end
            end

            assign busy_vec[gi]  = busy_reg;
            assign ready_vec[gi] = busy_reg && jrdy_reg && krdy_reg;
            assign op_vec[gi]    = op_reg;
            assign vj_vec[gi]    = vj_reg;
            assign vk_vec[gi]    = vk_reg;
            assign imm_vec[gi]   = imm_reg;
            assign dest_vec[gi]  = dest_reg;
            assign pc_vec[gi]    = pc_reg;
        end
    endgenerate

    logic               rs_valid_reg;
    logic [OP_LOG-1:0]  rs_op_reg;
    logic [31:0]        rs_vj_reg, rs_vk_reg, rs_imm_reg, rs_pc_reg;
    logic [ROB_LOG-1:0] rs_dest_reg;

    // Payload holds its last value when nothing issues; only valid/op signal an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_valid_reg <= 1'b0;
            rs_op_reg    <= OP_NOP;
            rs_vj_reg    <= '0;
            rs_vk_reg    <= '0;
            rs_imm_reg   <= '0;
            rs_dest_reg  <= '0;
            rs_pc_reg    <= '0;
        end else if (issue_go) begin
            rs_valid_reg <= 1'b1;
            rs_op_reg    <= op_vec[issue_idx];
            rs_vj_reg    <= vj_vec[issue_idx];
            rs_vk_reg    <= vk_vec[issue_idx];
            rs_imm_reg   <= imm_vec[issue_idx];
            rs_dest_reg  <= dest_vec[issue_idx];
            rs_pc_reg    <= pc_vec[issue_idx];
        end else begin
            rs_valid_reg <= 1'b0;
            rs_op_reg    <= OP_NOP;
        end
    end

    assign bus.RS_valid   = rs_valid_reg;
    assign bus.RS_op      = rs_op_reg;
    assign bus.RS_Vj      = rs_vj_reg;
    assign bus.RS_Vk      = rs_vk_reg;
    assign bus.RS_Imm     = rs_imm_reg;
    assign bus.RS_DestRob = rs_dest_reg;
    assign bus.RS_CurPC   = rs_pc_reg;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed vector table, hand-written corner sequences and a
// randomized run, all checked against an entry-list reference model.
module tb_reservation_station;
    localparam int RS_SIZE = 16;
    localparam int RS_LOG  = 4;
    localparam int ROB_LOG = 4;
    localparam int OP_LOG  = 6;
    localparam logic [OP_LOG-1:0] OP_NOP  = 6'd0;
    localparam logic [OP_LOG-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_LOG-1:0] OP_ADDI = 6'd2;

    logic clk = 1'b0;
    logic rst, rdy, clear;
    always #5 clk = ~clk;

    reservation_station_if #(.ROB_LOG(ROB_LOG), .OP_LOG(OP_LOG)) bus();

    reservation_station #(
        .RS_SIZE(RS_SIZE), .RS_LOG(RS_LOG), .ROB_LOG(ROB_LOG), .OP_LOG(OP_LOG), .OP_NOP(OP_NOP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rdy  (rdy),
        .clear(clear),
        .bus  (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain list of waiting ops plus the expected issue-bus contents.
    typedef struct {
        bit busy;
        logic [OP_LOG-1:0] op;
        logic [31:0] vj, vk, imm, pc;
        bit jr, kr;
        logic [ROB_LOG-1:0] qj, qk, dest;
    } ent_t;

    ent_t m[RS_SIZE];
    bit e_valid, e_nop_known, e_zero;
    logic [OP_LOG-1:0] e_op;
    logic [31:0] e_vj, e_vk, e_imm, e_pc;
    logic [ROB_LOG-1:0] e_dest;

    function automatic bit model_full();
        int cnt = 0;
        for (int i = 0; i < RS_SIZE; i++) if (m[i].busy) cnt++;
        return cnt == RS_SIZE;
    endfunction

    task automatic model_step();
        ent_t nm[RS_SIZE];
        int sel = -1;
        int fr = -1;
        nm = m;
        e_zero = 0;
        if (rst) begin
            foreach (nm[i]) nm[i].busy = 0;
            e_valid = 0; e_op = OP_NOP; e_nop_known = 1; e_zero = 1;
        end else if (!rdy) begin
            e_valid = 0; e_nop_known = 0;
        end else if (clear) begin
            foreach (nm[i]) nm[i].busy = 0;
            e_valid = 0; e_nop_known = 0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (m[i].busy && m[i].jr && m[i].kr && sel < 0) sel = i;
                if (!m[i].busy && fr < 0) fr = i;
            end
            if (sel >= 0) begin
                e_valid = 1; e_op = m[sel].op; e_vj = m[sel].vj; e_vk = m[sel].vk;
                e_imm = m[sel].imm; e_dest = m[sel].dest; e_pc = m[sel].pc;
                nm[sel].busy = 0;
            end else begin
                e_valid = 0; e_op = OP_NOP; e_nop_known = 1;
            end
            for (int i = 0; i < RS_SIZE; i++) begin
                if (m[i].busy && !m[i].jr) begin
                    if (bus.L_enable && bus.L_RobId == m[i].qj) begin nm[i].vj = bus.L_value; nm[i].jr = 1; end
                    else if (bus.B_enable && bus.B_RobId == m[i].qj) begin nm[i].vj = bus.B_value; nm[i].jr = 1; end
                end
                if (m[i].busy && !m[i].kr) begin
                    if (bus.L_enable && bus.L_RobId == m[i].qk) begin nm[i].vk = bus.L_value; nm[i].kr = 1; end
                    else if (bus.B_enable && bus.B_RobId == m[i].qk) begin nm[i].vk = bus.B_value; nm[i].kr = 1; end
                end
            end
            if (bus.D_enable && fr >= 0 && bus.D_op != OP_NOP) begin
                ent_t e;
                e.busy = 1; e.op = bus.D_op; e.imm = bus.D_Imm; e.pc = bus.D_CurPC;
                e.dest = bus.D_DestRob; e.qj = bus.D_Qj; e.qk = bus.D_Qk;
                e.vj = bus.D_Vj; e.jr = bus.D_Jrdy; e.vk = bus.D_Vk; e.kr = bus.D_Krdy;
                if (!e.jr && bus.L_enable && bus.L_RobId == e.qj) begin e.vj = bus.L_value; e.jr = 1; end
                else if (!e.jr && bus.B_enable && bus.B_RobId == e.qj) begin e.vj = bus.B_value; e.jr = 1; end
                if (!e.kr && bus.L_enable && bus.L_RobId == e.qk) begin e.vk = bus.L_value; e.kr = 1; end
                else if (!e.kr && bus.B_enable && bus.B_RobId == e.qk) begin e.vk = bus.B_value; e.kr = 1; end
                nm[fr] = e;
            end
        end
        m = nm;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".valid"}, bus.RS_valid, e_valid);
        if (e_valid) begin
            check({tag, ".op"},   bus.RS_op, e_op);
            check({tag, ".vj"},   bus.RS_Vj, e_vj);
            check({tag, ".vk"},   bus.RS_Vk, e_vk);
            check({tag, ".imm"},  bus.RS_Imm, e_imm);
            check({tag, ".dest"}, bus.RS_DestRob, e_dest);
            check({tag, ".pc"},   bus.RS_CurPC, e_pc);
        end else if (e_nop_known) begin
            check({tag, ".op_nop"}, bus.RS_op, OP_NOP);
        end
        if (e_zero) begin
            check({tag, ".vj0"}, bus.RS_Vj, 0);
            check({tag, ".vk0"}, bus.RS_Vk, 0);
            check({tag, ".imm0"}, bus.RS_Imm, 0);
            check({tag, ".dest0"}, bus.RS_DestRob, 0);
            check({tag, ".pc0"}, bus.RS_CurPC, 0);
        end
        check({tag, ".full"}, bus.full, model_full());
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_model(tag);
    endtask

    task automatic idle();
        rst = 0; rdy = 1; clear = 0;
        bus.D_enable = 0; bus.D_op = OP_NOP; bus.D_Vj = 0; bus.D_Vk = 0;
        bus.D_Jrdy = 1; bus.D_Krdy = 1; bus.D_Qj = 0; bus.D_Qk = 0;
        bus.D_Imm = 32'h20; bus.D_DestRob = 0; bus.D_CurPC = 32'h400;
        bus.B_enable = 0; bus.B_value = 0; bus.B_RobId = 0;
        bus.L_enable = 0; bus.L_value = 0; bus.L_RobId = 0;
    endtask

    task automatic dispatch(input logic [OP_LOG-1:0] op, input logic [31:0] vj, vk,
                            input bit jr, kr, input logic [ROB_LOG-1:0] qj, qk, dest);
        bus.D_enable = 1; bus.D_op = op; bus.D_Vj = vj; bus.D_Vk = vk;
        bus.D_Jrdy = jr; bus.D_Krdy = kr; bus.D_Qj = qj; bus.D_Qk = qk; bus.D_DestRob = dest;
    endtask

    typedef struct {
        bit rst, rdy, clr, den;
        logic [OP_LOG-1:0] op;
        logic [31:0] vj, vk;
        bit jr, kr;
        logic [ROB_LOG-1:0] qj, dest;
        bit ben; logic [ROB_LOG-1:0] btag; logic [31:0] bval;
        bit len; logic [ROB_LOG-1:0] ltag; logic [31:0] lval;
        bit x_valid; logic [OP_LOG-1:0] x_op; logic [31:0] x_vj; logic [ROB_LOG-1:0] x_dest; bit x_full;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // rst rdy clr den op vj vk jr kr qj dest | ben btag bval | len ltag lval | exp v op vj dest full
        vecs[0]  = '{1,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,     0,OP_NOP, 0,0,0};
        vecs[1]  = '{0,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,     0,OP_NOP, 0,0,0};
        vecs[2]  = '{0,1,0,1,OP_ADD, 5,7, 1,1, 0,3, 0,0,0, 0,0,0,     0,OP_NOP, 0,0,0};
        vecs[3]  = '{0,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,     1,OP_ADD, 5,3,0};
        vecs[4]  = '{0,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,     0,OP_NOP, 0,0,0};
        vecs[5]  = '{0,1,0,1,OP_ADDI,0,0, 0,1, 2,4, 0,0,0, 0,0,0,     0,OP_NOP, 0,0,0};
        vecs[6]  = '{0,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,     0,OP_NOP, 0,0,0};
        vecs[7]  = '{0,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,     0,OP_NOP, 0,0,0};
        vecs[8]  = '{0,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,     0,OP_NOP, 0,0,0};
        vecs[9]  = '{0,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 1,2,32'h10,0,OP_NOP, 0,0,0};
        vecs[10] = '{0,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,     1,OP_ADDI,32'h10,4,0};
        vecs[11] = '{0,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,     0,OP_NOP, 0,0,0};
        vecs[12] = '{0,1,0,1,OP_ADD, 0,1, 0,1, 4,5, 1,4,9, 0,0,0,     0,OP_NOP, 0,0,0};
        vecs[13] = '{0,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,     1,OP_ADD, 9,5,0};
        vecs[14] = '{0,1,0,0,OP_NOP, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,     0,OP_NOP, 0,0,0};

        foreach (m[i]) m[i].busy = 0;
        e_valid = 0; e_op = OP_NOP; e_nop_known = 0; e_zero = 0;
        idle();
        rst = 1;

        // Directed table: reset, plain issue, wake-up after a wait, dispatch bypass.
        for (int r = 0; r < 15; r++) begin
            idle();
            rst = vecs[r].rst; rdy = vecs[r].rdy; clear = vecs[r].clr;
            if (vecs[r].den)
                dispatch(vecs[r].op, vecs[r].vj, vecs[r].vk, vecs[r].jr, vecs[r].kr,
                         vecs[r].qj, 0, vecs[r].dest);
            bus.B_enable = vecs[r].ben; bus.B_RobId = vecs[r].btag; bus.B_value = vecs[r].bval;
            bus.L_enable = vecs[r].len; bus.L_RobId = vecs[r].ltag; bus.L_value = vecs[r].lval;
            cycle($sformatf("vec%0d", r));
            check($sformatf("vec%0d.valid", r), bus.RS_valid, vecs[r].x_valid);
            check($sformatf("vec%0d.op", r), bus.RS_op, vecs[r].x_op);
            if (vecs[r].x_valid || vecs[r].rst) begin
                check($sformatf("vec%0d.vj", r), bus.RS_Vj, vecs[r].x_vj);
                check($sformatf("vec%0d.dest", r), bus.RS_DestRob, vecs[r].x_dest);
            end
            check($sformatf("vec%0d.full", r), bus.full, vecs[r].x_full);
        end

        // Fill all entries, each waiting on its own tag; entry i waits on tag i.
        for (int i = 0; i < RS_SIZE; i++) begin
            idle();
            dispatch(OP_ADD, 0, 1, 0, 1, ROB_LOG'(i), 0, ROB_LOG'(i));
            cycle("fill");
        end
        check("fill.full", bus.full, 1);
        idle();
        dispatch(OP_ADD, 32'hdead, 1, 1, 1, 0, 0, 4'hf);
        cycle("drop");
        check("drop.full", bus.full, 1);
        idle();
        cycle("drop_idle");
        check("drop.no_issue", bus.RS_valid, 0);
        idle();
        bus.B_enable = 1; bus.B_RobId = 5; bus.B_value = 32'h55;
        cycle("wake5");
        check("wake5.no_issue_yet", bus.RS_valid, 0);
        check("wake5.still_full", bus.full, 1);
        idle();
        cycle("issue5");
        check("issue5.valid", bus.RS_valid, 1);
        check("issue5.vj", bus.RS_Vj, 32'h55);
        check("issue5.dest", bus.RS_DestRob, 5);
        check("issue5.full_clears", bus.full, 0);

        // Two entries wake together; lower index goes first, a freeze in between loses nothing.
        idle();
        bus.B_enable = 1; bus.B_RobId = 1; bus.B_value = 32'h11;
        bus.L_enable = 1; bus.L_RobId = 3; bus.L_value = 32'h33;
        cycle("wake13");
        idle();
        cycle("issue1");
        check("issue1.valid", bus.RS_valid, 1);
        check("issue1.dest", bus.RS_DestRob, 1);
        check("issue1.vj", bus.RS_Vj, 32'h11);
        idle();
        rdy = 0;
        cycle("freeze");
        check("freeze.valid", bus.RS_valid, 0);
        idle();
        cycle("issue3");
        check("issue3.valid", bus.RS_valid, 1);
        check("issue3.dest", bus.RS_DestRob, 3);
        check("issue3.vj", bus.RS_Vj, 32'h33);

        // Flush with a concurrent ready dispatch; then no tag can resurrect anything.
        idle();
        clear = 1;
        dispatch(OP_ADD, 1, 2, 1, 1, 0, 0, 7);
        cycle("clear");
        check("clear.valid", bus.RS_valid, 0);
        check("clear.full", bus.full, 0);
        for (int t = 0; t < RS_SIZE; t++) begin
            idle();
            bus.B_enable = 1; bus.B_RobId = ROB_LOG'(t); bus.B_value = 32'h77;
            cycle("post_clear");
            check("post_clear.valid", bus.RS_valid, 0);
        end
        idle();
        cycle("post_clear_idle");
        check("post_clear_idle.valid", bus.RS_valid, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy = ($urandom_range(0, 7) != 0);
            clear = ($urandom_range(0, 63) == 0);
            if (!model_full() && $urandom_range(0, 1) == 1) begin
                dispatch(($urandom_range(0, 15) == 0) ? OP_NOP : OP_LOG'($urandom_range(1, 3)),
                         $urandom, $urandom, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
                         ROB_LOG'($urandom), ROB_LOG'($urandom), ROB_LOG'($urandom));
                bus.D_Imm = $urandom; bus.D_CurPC = $urandom;
            end
            if (rdy) begin
                bus.B_enable = $urandom_range(0, 1); bus.B_RobId = ROB_LOG'($urandom); bus.B_value = $urandom;
                bus.L_enable = $urandom_range(0, 1); bus.L_RobId = ROB_LOG'($urandom); bus.L_value = $urandom;
                if (bus.L_RobId == bus.B_RobId) bus.L_enable = 0;
            end
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
